fifo_burst_reader: RTL and testbench

//  Downstream drain stage for the synchronous FIFO: on a start command, pops exactly
//  len words using fifo_rd_en, absorbs the FIFO's 1-cycle read latency and presents the

---
 rtl/fifo_burst_reader.sv | 114 +++++++++++
 tb/tb_fifo_burst_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Drains exactly len words from a 1-cycle-latency synchronous FIFO and streams them out.
// A 2-entry buffer plus the in-flight read form the credit pool that gates pops.
module fifo_burst_reader #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_left,
  output logic             fifo_rd_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       o_state
);

  // Stream handshake: a beat transfers on a posedge where m_valid && m_ready; once
  // m_valid is high it stays high with m_data stable until that transfer (or reset).

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_issue_left;
  logic [LEN_W-1:0] r_words_left;
  logic             r_inflight;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;
  logic [1:0]       r_buf_cnt;
  logic             w_xfer;
  logic             w_pop;
  logic [2:0]       w_occ;

  assign m_valid    = (r_buf_cnt != 2'd0);
  assign m_data     = r_buf0;
  assign w_xfer     = m_valid && m_ready;
  // Occupancy after this edge if no pop: buffered + in flight - leaving
  assign w_occ      = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign w_pop      = !rst && (r_state == S_RUN) && !fifo_empty &&
                      (r_issue_left != '0) && (w_occ < 3'd2);
  assign fifo_rd_en = w_pop;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign words_left = r_words_left;
  assign o_state    = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len != '0) ? S_RUN : S_DONE;
      S_RUN:   if ((r_issue_left == '0) || (w_pop && (r_issue_left == LEN_ONE))) w_next = S_DRAIN;
      S_DRAIN: if (w_xfer && (r_words_left == LEN_ONE)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_issue_left <= '0;
      r_words_left <= '0;
      r_inflight   <= 1'b0;
      r_buf0       <= '0;
      r_buf1       <= '0;
      r_buf_cnt    <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_pop;
      if ((r_state == S_IDLE) && start) begin
        r_issue_left <= len;
        r_words_left <= len;
      end else begin
        if (w_pop)  r_issue_left <= r_issue_left - LEN_ONE;
        if (w_xfer) r_words_left <= r_words_left - LEN_ONE;
      end
      // Capture of the in-flight word and head pop may coincide; order is preserved
      case ({r_inflight, w_xfer})
        2'b10: begin
          if (r_buf_cnt == 2'd0) r_buf0 <= fifo_data_out;
          else                   r_buf1 <= fifo_data_out;
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= fifo_data_out;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, word-order scoreboard and a per-cycle
// behavioural model of busy/done/words_left and the stream rules.
module tb_fifo_burst_reader;
  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, fifo_rd_en, m_valid;
  logic [LEN_W-1:0] words_left;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       o_state;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic             m_ready = 1'b0;
  logic             wr_valid = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // model state
  int  cyc = 0;
  bit  m_act = 0;
  bit  m_done_now = 0;
  bit  post_rst = 0;
  bit  prev_stall = 0;
  logic [WIDTH-1:0] prev_data = '0;
  int  m_left = 0;
  int  m_len = 0;
  int  b_pops = 0, b_xfers = 0;
  int  first_pop_cyc = -1, last_pop_cyc = -1, first_valid_cyc = -1;
  int  first_xfer_cyc = -1, last_xfer_cyc = -1, done_cyc = -1;
  logic [WIDTH-1:0] first_data = '0;
  bit  rnd_stop = 0;

  fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .busy(busy), .done(done), .words_left(words_left),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .o_state(o_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // synchronous FIFO with one-cycle read latency and registered empty flag
  always @(posedge clk) begin
    if (flush) begin
      fifo_q.delete();
    end else begin
      if (fifo_rd_en && (fifo_q.size() > 0)) fifo_data_out <= fifo_q.pop_front();
      if (wr_valid) fifo_q.push_back(wr_data);
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model + scoreboard, compared mid-cycle
  always @(negedge clk) begin
    bit nd;
    cyc++;
    nd = 1'b0;
    if (rst) begin
      chk("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
      m_act = 0; m_left = 0; m_done_now = 0; prev_stall = 0;
      b_pops = 0; b_xfers = 0; post_rst = 1;
      exp_q.delete();
    end else begin
      if (post_rst) begin
        chk("post_reset_valid", {31'd0, m_valid}, 32'd0);
        chk("post_reset_data", {16'd0, m_data}, 32'd0);
        post_rst = 0;
      end
      chk("busy", {31'd0, busy}, {31'd0, m_act});
      chk("done", {31'd0, done}, {31'd0, m_done_now});
      chk("words_left", {24'd0, words_left}, m_left);
      if (!m_act) chk("valid_idle", {31'd0, m_valid}, 32'd0);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", {16'd0, m_data}, {16'd0, prev_data});
      end
      if (fifo_rd_en) begin
        chk("pop_when_empty", {31'd0, fifo_empty}, 32'd0);
        b_pops++;
        chk("pop_beyond_len", (b_pops <= m_len) ? 32'd1 : 32'd0, 32'd1);
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      if (m_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL m_data: got 0x%0h, expected no beat (t=%0t)", m_data, $time);
        end else begin
          chk("m_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
        end
        b_xfers++;
        if (first_xfer_cyc < 0) begin
          first_xfer_cyc = cyc;
          first_data = m_data;
        end
        last_xfer_cyc = cyc;
        m_left--;
        if (m_act && (m_left == 0)) begin
          m_act = 0;
          nd = 1'b1;
        end
      end
      chk("credit", ((b_pops - b_xfers) <= 2) ? 32'd1 : 32'd0, 32'd1);
      if (done) done_cyc = cyc;
      if (start && !m_act && !m_done_now) begin
        m_len = len; b_pops = 0; b_xfers = 0;
        first_pop_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1;
        first_xfer_cyc = -1; last_xfer_cyc = -1;
        if (len == 0) nd = 1'b1;
        else begin
          m_act = 1;
          m_left = len;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      m_done_now = nd;
    end
    if (flush) exp_q.delete();
    else if (wr_valid) exp_q.push_back(wr_data);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [WIDTH-1:0] w);
    wr_valid = 1'b1;
    wr_data = w;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1;
    len = l[LEN_W-1:0];
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    chk("done_timeout", {31'd0, done}, 32'd1);
    tick();
  endtask

  task automatic wait_xfers(input int n, input int budget);
    for (int i = 0; i < budget && b_xfers < n; i++) tick();
    chk("beat_timeout", (b_xfers >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    // 1: reset with FIFO holding 3 words
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) put(16'h00A0 + 16'(i));
    rst = 1'b1;
    tick(); tick();
    chk("t1_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd0);
    chk("t1_valid", {31'd0, m_valid}, 32'd0);
    chk("t1_data", {16'd0, m_data}, 32'd0);
    chk("t1_words_left", {24'd0, words_left}, 32'd0);
    chk("t1_state", {30'd0, o_state}, 32'd0);
    rst = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    // 2: 4-word burst, sink always ready
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) put(16'(i));
    pulse_start(4);
    wait_done(50);
    chk("t2_pops", b_pops, 32'd4);
    chk("t2_pop_run", last_pop_cyc - first_pop_cyc, 32'd3);
    chk("t2_latency", first_valid_cyc - first_pop_cyc, 32'd2);
    chk("t2_b2b", last_xfer_cyc - first_xfer_cyc, 32'd3);
    chk("t2_first_data", {16'd0, first_data}, 32'h0001);
    chk("t2_done_after", done_cyc - last_xfer_cyc, 32'd1);

    // 3: 8-word burst with a 5-cycle stall after the first beat
    for (int i = 0; i < 8; i++) put(16'($urandom_range(0, 16'hFFFF)));
    pulse_start(8);
    wait_xfers(1, 50);
    m_ready = 1'b0;
    repeat (5) tick();
    chk("t3_credit_full", b_pops - b_xfers, 32'd2);
    chk("t3_valid_held", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    wait_done(100);
    chk("t3_beats", b_xfers, 32'd8);

    // 4: FIFO runs dry mid-burst, refilled 10 cycles later
    for (int i = 0; i < 3; i++) put(16'h4000 + 16'(i));
    pulse_start(6);
    repeat (10) tick();
    chk("t4_pops_paused", b_pops, 32'd3);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    for (int i = 3; i < 6; i++) put(16'h4000 + 16'(i));
    wait_done(100);
    chk("t4_beats", b_xfers, 32'd6);

    // 5: zero-length burst, then start while busy
    pulse_start(0);
    chk("t5_done_len0", {31'd0, done}, 32'd1);
    chk("t5_no_pops", b_pops, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) put(16'h5000 + 16'(i));
    pulse_start(3);
    pulse_start(7);
    wait_done(100);
    chk("t5_beats", b_xfers, 32'd3);
    chk("t5_pops", b_pops, 32'd3);

    // 6: reset mid-burst, then a normal 2-word burst
    for (int i = 0; i < 10; i++) put(16'h6000 + 16'(i));
    pulse_start(10);
    wait_xfers(4, 100);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    chk("t6_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    put(16'h7001);
    put(16'h7002);
    pulse_start(2);
    wait_done(50);
    chk("t6_beats", b_xfers, 32'd2);

    // randomized bursts: random lengths, trickled writes, random backpressure
    for (int b = 0; b < 8; b++) begin
      int l;
      l = $urandom_range(1, 12);
      rnd_stop = 0;
      fork
        begin
          for (int i = 0; i < l; i++) begin
            put(16'($urandom_range(0, 16'hFFFF)));
            repeat ($urandom_range(0, 3)) tick();
          end
        end
        begin
          pulse_start(l);
          wait_done(600);
          chk("rnd_beats", b_xfers, l);
          rnd_stop = 1;
        end
        begin
          while (!rnd_stop) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
          end
        end
      join
      m_ready = 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
